fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, computes the next PC from the redirect controls the decode-stage controller produces (`pc_src`, `jump`, stall/flush), drives the instruction-memory address, and holds the IF/ID pipeline register. It sits directly upstream of decode and consumes the controller's `PC_stall`/`IF_ID_en`/`IF_flush`/`PC_src`/`jump` outputs in the same cycle they are produced.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0000, instruction word injected on flush (`sll $0,$0,0`).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_en` in 1: PC load enable (controller `PC_stall`, 1 = advance, 0 = hold).
- `if_id_en` in 1: IF/ID register load enable (controller `IF_ID_en`).
- `if_flush` in 1: replace incoming fetch with NOP.
- `pc_src` in 1: 1 = take redirect target, 0 = PC+4.
- `jump` in 2: target select: 00 branch, 01 j, 10 jr/jalr, 11 jal.
- `br_offset` in 32: sign-extended branch immediate (word offset, unshifted).
- `jr_target` in 32: forwarded rs value for jr/jalr.
- `imem_rdata` in 32: instruction at `imem_addr` (combinational memory).
- `imem_addr` out 32: current PC.
- `IF_ID_inst` out 32: registered instruction.
- `IF_ID_pc4` out 32: registered PC+4 of that instruction (link address, branch base).
- `IF_ID_valid` out 1: 1 = real instruction, 0 = bubble.

## Operation
- `pc4 = pc + 4`, 32-bit modulo (wrap 32'hFFFF_FFFC -> 0).
- Redirect target from decode-side values (`IF_ID_pc4`, `IF_ID_inst`):
  - 00: `IF_ID_pc4 + (br_offset << 2)`, modulo 2^32.
  - 01/11: `{IF_ID_pc4[31:28], IF_ID_inst[25:0], 2'b00}`.
  - 10: `jr_target` unmodified (no alignment check).
- PC update priority: `rst` -> `RESET_PC`; else `pc_en==0` -> hold (redirect ignored; decode re-evaluates next cycle); else `pc_src` -> target; else `pc4`.
- IF/ID update priority: `rst` -> `{NOP_INST, 0, valid 0}`; else `if_id_en==0` -> hold all three fields (hold beats flush); else `if_flush` -> `{NOP_INST, pc4, valid 0}`; else `{imem_rdata, pc4, valid 1}`.
- No internal FSM beyond the two registers; a 1-bit `first` flag suppresses nothing, it is not present.

## Timing
- Reset values: `imem_addr=RESET_PC`, `IF_ID_inst=NOP_INST`, `IF_ID_pc4=0`, `IF_ID_valid=0`.
- Fetch latency 1 cycle: `imem_rdata` sampled at edge N appears on `IF_ID_*` after edge N.
- Taken branch/jump resolved in ID: one delay-slot fetch is squashed via `if_flush`; penalty exactly 1 bubble.
- Load-use stall (`pc_en=0`, `if_id_en=0`): PC and IF/ID frozen for the stall cycle; same `imem_addr` re-presented.
- `pc_en=0` with `pc_src=1` same cycle: no redirect; PC holds.
- `rst` mid-stall or mid-redirect: reset wins, next cycle fetches `RESET_PC`.
- `imem_addr` is a register output, never combinational from inputs.

## Structure
- Shared package `mips_pkg`: `JMP_BR=2'b00`, `JMP_J=2'b01`, `JMP_JR=2'b10`, `JMP_JAL=2'b11`, `NOP_INST`, `RESET_PC` default.
- One combinational sub-module `next_pc_sel` (inputs `pc4`, `IF_ID_pc4`, `IF_ID_inst`, `br_offset`, `jr_target`, `jump`, `pc_src`; output next PC); registers stay in `fetch_stage`.

## Test plan
- Reset then free run, `pc_en=if_id_en=1`, no redirect -> `imem_addr` 0,4,8,12; `IF_ID_pc4` lags by one cycle, `IF_ID_valid=1` from cycle 2.
- Branch at 0x10 (`IF_ID_pc4=0x14`), `br_offset=32'hFFFF_FFFC`, `pc_src=1`, `jump=00`, `if_flush=1` -> next `imem_addr=0x04`, `IF_ID_valid=0`, `IF_ID_inst=0`.
- j with `IF_ID_pc4=0x4000_0010`, `IF_ID_inst[25:0]=26'h000_0040` -> next `imem_addr=0x4000_0100`; jal identical target.
- jr with `jr_target=0x0000_0200` -> next `imem_addr=0x200`; one bubble.
- Stall: `pc_en=0`, `if_id_en=0`, `if_flush=1`, `pc_src=1` at PC=0x20 -> PC stays 0x20, IF/ID unchanged; release -> PC 0x24.
- PC=32'hFFFF_FFFC, no redirect -> wraps to 0; assert `rst` during stall -> PC=`RESET_PC`, `IF_ID_valid=0` next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: jump-target encodings, reset PC and NOP word,
// plus the branch-target helper used by the fetch redirect logic.
package mips_pkg;

    typedef enum logic [1:0] {
        JMP_BR  = 2'b00,
        JMP_J   = 2'b01,
        JMP_JR  = 2'b10,
        JMP_JAL = 2'b11
    } jump_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Branch immediate is a word offset; scale to bytes, wrap modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] base_pc4,
                                                  input logic [31:0] word_off);
        return base_pc4 + (word_off << 2);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: controller redirect/stall controls, instruction-memory
// port and the IF/ID pipeline register outputs.
interface fetch_if;
    import mips_pkg::*;

    logic        pc_en;
    logic        if_id_en;
    logic        if_flush;
    logic        pc_src;
    jump_e       jump;
    logic [31:0] br_offset;
    logic [31:0] jr_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;

    // Controller / memory side.
    modport master (
        output pc_en, if_id_en, if_flush, pc_src, jump, br_offset, jr_target, imem_rdata,
        input  imem_addr, IF_ID_inst, IF_ID_pc4, IF_ID_valid
    );

    // Fetch stage side.
    modport slave (
        input  pc_en, if_id_en, if_flush, pc_src, jump, br_offset, jr_target, imem_rdata,
        output imem_addr, IF_ID_inst, IF_ID_pc4, IF_ID_valid
    );

endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Combinational next-PC mux: sequential PC+4 or the decode-resolved redirect
// target (branch, j/jal pseudo-direct, jr/jalr register).
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [31:0] if_id_pc4,
    input  logic [31:0] if_id_inst,
    input  logic [31:0] br_offset,
    input  logic [31:0] jr_target,
    input  jump_e       jump,
    input  logic        pc_src,
    output logic [31:0] next_pc
);

    // Opcode field is not part of any target computation.
    logic unused_opcode;
    assign unused_opcode = ^if_id_inst[31:26];

    always_comb begin
        // NOTE: default assigned first so every path drives next_pc; no latch.
        next_pc = pc4;
        if (pc_src) begin
            case (jump)
                JMP_BR:          next_pc = branch_target(if_id_pc4, br_offset);
                JMP_J, JMP_JAL:  next_pc = {if_id_pc4[31:28], if_id_inst[25:0], 2'b00};
                JMP_JR:          next_pc = jr_target;
                default:         next_pc = pc4;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID
// pipeline register. imem_addr comes straight from the PC register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
    input logic   clk,
    input logic   rst,
    fetch_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    assign pc4 = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc4        (pc4),
        .if_id_pc4  (pc4_q),
        .if_id_inst (inst_q),
        .br_offset  (bus.br_offset),
        .jr_target  (bus.jr_target),
        .jump       (bus.jump),
        .pc_src     (bus.pc_src),
        .next_pc    (next_pc)
    );

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;

        // A stalled PC ignores any redirect; decode re-evaluates it next cycle.
        if (bus.pc_en) begin
            pc_d = next_pc;
        end

        // Hold takes priority over flush so a stalled instruction is not lost.
        if (bus.if_id_en) begin
            if (bus.if_flush) begin
                inst_d  = NOP_INST;
                pc4_d   = pc4;
                valid_d = 1'b0;
            end else begin
                inst_d  = bus.imem_rdata;
                pc4_d   = pc4;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers sample pre-edge values together.
        if (rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.IF_ID_inst  = inst_q;
    assign bus.IF_ID_pc4   = pc4_q;
    assign bus.IF_ID_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free run, branch/j/jal/jr redirects,
// load-use stall, PC wrap and reset during a stall.
module tb_fetch_stage;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fetch_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: address-tagged words, plus a j/jal word at 0x4000_000C.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4000_000C) return 32'h0800_0040;
        return {8'h24, a[23:0]};
    endfunction

    always_comb bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_controls();
        bus.pc_en     = 1'b1;
        bus.if_id_en  = 1'b1;
        bus.if_flush  = 1'b0;
        bus.pc_src    = 1'b0;
        bus.jump      = JMP_BR;
        bus.br_offset = 32'h0;
        bus.jr_target = 32'h0;
    endtask

    task automatic redirect_jr(input logic [31:0] tgt);
        bus.pc_src    = 1'b1;
        bus.jump      = JMP_JR;
        bus.jr_target = tgt;
        bus.if_flush  = 1'b1;
        tick();
        idle_controls();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_controls();
        tick();
        tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.IF_ID_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want %h", bus.IF_ID_inst, 32'h0); end
        checks++; if (bus.IF_ID_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want %h", bus.IF_ID_pc4, 32'h0); end
        checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want %b", bus.IF_ID_valid, 1'b0); end
        rst = 1'b0;
    endtask

    // Runs from 0 up to imem_addr=0x14 with IF/ID holding the fetch from 0x10.
    task automatic test_free_run();
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (bus.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL free_addr%0d: got %h want %h", i, bus.imem_addr, 32'(4 * i)); end
            checks++; if (bus.IF_ID_pc4 !== 32'(4 * i)) begin errors++; $display("FAIL free_pc4%0d: got %h want %h", i, bus.IF_ID_pc4, 32'(4 * i)); end
            checks++; if (bus.IF_ID_inst !== {8'h24, 24'(4 * (i - 1))}) begin errors++; $display("FAIL free_inst%0d: got %h want %h", i, bus.IF_ID_inst, {8'h24, 24'(4 * (i - 1))}); end
            checks++; if (bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL free_valid%0d: got %b want 1", i, bus.IF_ID_valid); end
        end
    endtask

    task automatic test_branch();
        bus.pc_src    = 1'b1;
        bus.jump      = JMP_BR;
        bus.br_offset = 32'hFFFF_FFFC;
        bus.if_flush  = 1'b1;
        tick();
        idle_controls();
        checks++; if (bus.imem_addr !== 32'h04) begin errors++; $display("FAIL br_addr: got %h want %h", bus.imem_addr, 32'h04); end
        checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b want 0", bus.IF_ID_valid); end
        checks++; if (bus.IF_ID_inst !== 32'h0) begin errors++; $display("FAIL br_inst: got %h want %h", bus.IF_ID_inst, 32'h0); end
        checks++; if (bus.IF_ID_pc4 !== 32'h18) begin errors++; $display("FAIL br_pc4: got %h want %h", bus.IF_ID_pc4, 32'h18); end
        tick();
        checks++; if (bus.imem_addr !== 32'h08) begin errors++; $display("FAIL br_after_addr: got %h want %h", bus.imem_addr, 32'h08); end
        checks++; if (bus.IF_ID_inst !== 32'h2400_0004) begin errors++; $display("FAIL br_after_inst: got %h want %h", bus.IF_ID_inst, 32'h2400_0004); end
        checks++; if (bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL br_after_valid: got %b want 1", bus.IF_ID_valid); end
    endtask

    task automatic test_jr();
        redirect_jr(32'h0000_0200);
        checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL jr_addr: got %h want %h", bus.imem_addr, 32'h200); end
        checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL jr_bubble: got %b want 0", bus.IF_ID_valid); end
        tick();
        checks++; if (bus.imem_addr !== 32'h204) begin errors++; $display("FAIL jr_next_addr: got %h want %h", bus.imem_addr, 32'h204); end
        checks++; if (bus.IF_ID_pc4 !== 32'h204) begin errors++; $display("FAIL jr_next_pc4: got %h want %h", bus.IF_ID_pc4, 32'h204); end
        checks++; if (bus.IF_ID_inst !== 32'h2400_0200) begin errors++; $display("FAIL jr_next_inst: got %h want %h", bus.IF_ID_inst, 32'h2400_0200); end
        checks++; if (bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL jr_next_valid: got %b want 1", bus.IF_ID_valid); end
    endtask

    // Lands the j/jal word at 0x4000_000C in IF/ID, then resolves it.
    task automatic test_jump(input jump_e kind);
        redirect_jr(32'h4000_000C);
        tick();
        checks++; if (bus.IF_ID_pc4 !== 32'h4000_0010) begin errors++; $display("FAIL jmp%0d_setup_pc4: got %h want %h", kind, bus.IF_ID_pc4, 32'h4000_0010); end
        bus.pc_src   = 1'b1;
        bus.jump     = kind;
        bus.if_flush = 1'b1;
        tick();
        idle_controls();
        checks++; if (bus.imem_addr !== 32'h4000_0100) begin errors++; $display("FAIL jmp%0d_addr: got %h want %h", kind, bus.imem_addr, 32'h4000_0100); end
        checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL jmp%0d_bubble: got %b want 0", kind, bus.IF_ID_valid); end
    endtask

    task automatic test_stall();
        redirect_jr(32'h0000_001C);
        tick();
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL stall_setup_addr: got %h want %h", bus.imem_addr, 32'h20); end
        bus.pc_en     = 1'b0;
        bus.if_id_en  = 1'b0;
        bus.if_flush  = 1'b1;
        bus.pc_src    = 1'b1;
        bus.jump      = JMP_JR;
        bus.jr_target = 32'h300;
        tick();
        idle_controls();
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL stall_addr: got %h want %h", bus.imem_addr, 32'h20); end
        checks++; if (bus.IF_ID_inst !== 32'h2400_001C) begin errors++; $display("FAIL stall_inst: got %h want %h", bus.IF_ID_inst, 32'h2400_001C); end
        checks++; if (bus.IF_ID_pc4 !== 32'h20) begin errors++; $display("FAIL stall_pc4: got %h want %h", bus.IF_ID_pc4, 32'h20); end
        checks++; if (bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", bus.IF_ID_valid); end
        tick();
        checks++; if (bus.imem_addr !== 32'h24) begin errors++; $display("FAIL release_addr: got %h want %h", bus.imem_addr, 32'h24); end
        checks++; if (bus.IF_ID_inst !== 32'h2400_0020) begin errors++; $display("FAIL release_inst: got %h want %h", bus.IF_ID_inst, 32'h2400_0020); end
        checks++; if (bus.IF_ID_pc4 !== 32'h24) begin errors++; $display("FAIL release_pc4: got %h want %h", bus.IF_ID_pc4, 32'h24); end
    endtask

    task automatic test_wrap_reset();
        redirect_jr(32'hFFFF_FFFC);
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_addr: got %h want %h", bus.imem_addr, 32'hFFFF_FFFC); end
        tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.IF_ID_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want %h", bus.IF_ID_pc4, 32'h0); end
        checks++; if (bus.IF_ID_inst !== 32'h24FF_FFFC) begin errors++; $display("FAIL wrap_inst: got %h want %h", bus.IF_ID_inst, 32'h24FF_FFFC); end
        tick();
        tick();
        checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL prereset_addr: got %h want %h", bus.imem_addr, 32'h8); end
        rst           = 1'b1;
        bus.pc_en     = 1'b0;
        bus.if_id_en  = 1'b0;
        bus.pc_src    = 1'b1;
        bus.jump      = JMP_JR;
        bus.jr_target = 32'h300;
        tick();
        rst = 1'b0;
        idle_controls();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rststall_addr: got %h want %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL rststall_valid: got %b want 0", bus.IF_ID_valid); end
        checks++; if (bus.IF_ID_inst !== 32'h0) begin errors++; $display("FAIL rststall_inst: got %h want %h", bus.IF_ID_inst, 32'h0); end
        checks++; if (bus.IF_ID_pc4 !== 32'h0) begin errors++; $display("FAIL rststall_pc4: got %h want %h", bus.IF_ID_pc4, 32'h0); end
        tick();
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL postrst_addr: got %h want %h", bus.imem_addr, 32'h4); end
        checks++; if (bus.IF_ID_inst !== 32'h2400_0000) begin errors++; $display("FAIL postrst_inst: got %h want %h", bus.IF_ID_inst, 32'h2400_0000); end
        checks++; if (bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL postrst_valid: got %b want 1", bus.IF_ID_valid); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch();
        test_jr();
        test_jump(JMP_J);
        test_jump(JMP_JAL);
        test_stall();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
